alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (legal values 8..64).
REQ-002 The block SHALL have parameter CNT_W, default $clog2(WIDTH), giving the multiply iteration counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port valid_in, input, 1 bit: an operation is presented.
REQ-006 The block SHALL have port ALUOp, input, 2 bits: main-decoder operation class.
REQ-007 The block SHALL have port Funct, input, 6 bits: R-type function field.
REQ-008 The block SHALL have port SrcA, input, WIDTH bits: operand A.
REQ-009 The block SHALL have port SrcB, input, WIDTH bits: operand B.
REQ-010 The block SHALL have port flush, input, 1 bit: synchronous abort of an in-flight multiply.
REQ-011 The block SHALL have port ready_out, output, 1 bit: the block can accept an operation this cycle.
REQ-012 The block SHALL have port busy, output, 1 bit: a multiply is in progress.
REQ-013 The block SHALL have port valid_out, output, 1 bit: result/zero/op_out are valid; single-cycle pulse.
REQ-014 The block SHALL have port result, output, WIDTH bits: registered result.
REQ-015 The block SHALL have port zero, output, 1 bit: registered flag, result == 0.
REQ-016 The block SHALL have port op_out, output, 3 bits: ALUControl code of the completed operation.

Function
REQ-017 Decode SHALL map ALUOp 00->010 (add), ALUOp 01->100 (sub), ALUOp 11->010 (add).
REQ-018 For ALUOp 10, decode SHALL map Funct 100000->010 (add), 100010->100 (sub), 100100->000 (and), 100101->001 (or), 101010->110 (slt), 011100->101 (mul); any other Funct SHALL map to 010 (add).
REQ-019 An operation SHALL be accepted on a rising edge where valid_in=1 and ready_out=1; in every other cycle valid_in, ALUOp, Funct, SrcA and SrcB SHALL be ignored.
REQ-020 The FSM SHALL have states IDLE and MUL_RUN; ready_out SHALL equal (state==IDLE); busy SHALL equal (state==MUL_RUN).
REQ-021 add, sub, and, or and slt SHALL be single-cycle: result, zero, op_out and valid_out=1 are registered on the accept edge, and the state SHALL stay IDLE, so back-to-back issue is allowed every cycle.
REQ-022 add and sub SHALL wrap modulo 2^WIDTH; no carry or overflow output exists.
REQ-023 slt SHALL compare SrcA and SrcB as two's complement and return 1 if SrcA < SrcB, zero-extended to WIDTH.
REQ-024 On a mul accept edge the block SHALL latch the multiplicand (SrcA) and multiplier (SrcB), clear the accumulator and counter, and enter MUL_RUN; valid_out SHALL be 0 on that edge.
REQ-025 On each MUL_RUN edge, if multiplier bit 0 is 1 the block SHALL add the multiplicand to the accumulator (mod 2^WIDTH), then shift the multiplicand left 1, shift the multiplier right 1, and increment the counter.
REQ-026 On the MUL_RUN edge where counter == WIDTH-1, the block SHALL register result = final accumulator (low WIDTH bits of the product), zero, op_out=101 and valid_out=1, and return to IDLE.
REQ-027 mul latency SHALL be WIDTH+1 cycles from the accept edge to the valid_out cycle; busy SHALL be high for exactly WIDTH cycles.
REQ-028 valid_out SHALL be 1 for exactly one cycle per completed operation and 0 otherwise; result, zero and op_out SHALL hold their values until the next completion.
REQ-029 flush=1 on an edge in MUL_RUN SHALL return the block to IDLE with no valid_out, leaving result, zero and op_out unchanged.
REQ-030 flush=1 in IDLE SHALL have no effect, and an operation accepted on that same edge SHALL proceed normally.

Reset
REQ-031 rst_n=0 SHALL immediately force state=IDLE, valid_out=0, result=0, zero=1, op_out=010, and clear the counter, accumulator and operand registers, regardless of the clock.
REQ-032 Reset during MUL_RUN SHALL abort the multiply with no later completion.
REQ-033 ready_out SHALL be 1 in the first cycle after rst_n deasserts.

Verification (WIDTH=32)
REQ-034 ALUOp=00, SrcA=5, SrcB=7 -> next cycle valid_out=1, result=12, zero=0, op_out=010.
REQ-035 ALUOp=01, SrcA=SrcB=0x1234 -> result=0, zero=1; ALUOp=10, Funct=101010, SrcA=0xFFFFFFFF, SrcB=1 -> result=1.
REQ-036 Funct=011100, SrcA=6, SrcB=7 -> busy high for 32 cycles, ready_out low; valid_in pulses during busy ignored; valid_out 33 cycles after accept with result=42.
REQ-037 mul with SrcA=0xFFFFFFFF, SrcB=2 -> result=0xFFFFFFFE; mul with SrcB=0 -> result=0, zero=1.
REQ-038 flush at cycle 10 of a mul -> no valid_out, ready_out=1 next cycle, previous result retained.
REQ-039 rst_n pulsed low at cycle 10 of a mul -> immediately valid_out=0, result=0, zero=1; no completion after release.
REQ-040 Undefined Funct=111111 with ALUOp=10, SrcA=3, SrcB=4 -> result=7, op_out=010; back-to-back add, or, and on consecutive cycles -> three consecutive valid_out pulses.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execution unit: single-cycle add/sub/and/or/slt plus an iterative
// shift-and-add multiply that keeps the unit busy for WIDTH cycles.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             flush,
    output logic             ready_out,
    output logic             busy,
    output logic             valid_out,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [2:0]       op_out
);

    typedef enum logic {IDLE = 1'b0, MUL_RUN = 1'b1} state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic [2:0]         op_q, op_d;
    logic               valid_q, valid_d;

    logic [2:0]         alu_ctrl;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   acc_sum;
    logic               accept;
    logic               mul_last;

    always_comb begin
        alu_ctrl = OP_ADD;
        case (ALUOp)
            2'b01:   alu_ctrl = OP_SUB;
            2'b10: begin
                case (Funct)
                    6'b100010: alu_ctrl = OP_SUB;
                    6'b100100: alu_ctrl = OP_AND;
                    6'b100101: alu_ctrl = OP_OR;
                    6'b101010: alu_ctrl = OP_SLT;
                    6'b011100: alu_ctrl = OP_MUL;
                    default:   alu_ctrl = OP_ADD;
                endcase
            end
            default: alu_ctrl = OP_ADD;
        endcase
    end

    always_comb begin
        alu_res = SrcA + SrcB;
        case (alu_ctrl)
            OP_SUB:  alu_res = SrcA - SrcB;
            OP_AND:  alu_res = SrcA & SrcB;
            OP_OR:   alu_res = SrcA | SrcB;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            default: alu_res = SrcA + SrcB;
        endcase
    end

    assign accept   = valid_in && (state_q == IDLE);
    assign mul_last = (cnt_q == CNT_W'(WIDTH-1));
    assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && alu_ctrl == OP_MUL) state_d = MUL_RUN;
            MUL_RUN: if (flush || mul_last)            state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_out = (state_q == IDLE);
        busy      = (state_q == MUL_RUN);
    end

    // Datapath next-state; flush wins over a completion landing on the same edge.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        op_d     = op_q;
        valid_d  = 1'b0;
        if (state_q == IDLE && accept) begin
            if (alu_ctrl == OP_MUL) begin
                mcand_d  = SrcA;
                mplier_d = SrcB;
                acc_d    = '0;
                cnt_d    = '0;
            end else begin
                result_d = alu_res;
                zero_d   = (alu_res == '0);
                op_d     = alu_ctrl;
                valid_d  = 1'b1;
            end
        end else if (state_q == MUL_RUN && !flush) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (mul_last) begin
                result_d = acc_sum;
                zero_d   = (acc_sum == '0);
                op_d     = OP_MUL;
                valid_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            op_q     <= OP_ADD;
            valid_q  <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            op_q     <= op_d;
            valid_q  <= valid_d;
        end
    end

    assign valid_out = valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign op_out    = op_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vectors checked every cycle against a
// behavioural model, plus literal expectations on key vectors.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic [1:0]  ALUOp;
    logic [5:0]  Funct;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        flush;
    logic        ready_out;
    logic        busy;
    logic        valid_out;
    logic [31:0] result;
    logic        zero;
    logic [2:0]  op_out;

    int vectors = 0;
    int miscompares = 0;
    bit cmp_en = 0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ALUOp(ALUOp),
        .Funct(Funct), .SrcA(SrcA), .SrcB(SrcB), .flush(flush),
        .ready_out(ready_out), .busy(busy), .valid_out(valid_out),
        .result(result), .zero(zero), .op_out(op_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: countdown of remaining multiply cycles plus the full product.
    int          m_left;
    logic        m_valid;
    logic [31:0] m_res;
    logic        m_zero;
    logic [2:0]  m_op;
    logic [31:0] m_prod;
    logic [63:0] prod64;
    logic [2:0]  code;

    function automatic logic [2:0] decode(input logic [1:0] aop, input logic [5:0] fn);
        if (aop == 2'b01) return 3'b100;
        if (aop != 2'b10) return 3'b010;
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b100;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b110;
            6'b011100: return 3'b101;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic [31:0] eval(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'b100:  return a - b;
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b110:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a + b;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_valid = 0; m_res = 0; m_zero = 1; m_op = 3'b010; m_prod = 0;
        end else begin
            m_valid = 0;
            if (m_left > 0) begin
                if (flush) m_left = 0;
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_valid = 1; m_res = m_prod; m_zero = (m_prod == 0); m_op = 3'b101;
                    end
                end
            end else if (valid_in) begin
                code = decode(ALUOp, Funct);
                if (code == 3'b101) begin
                    prod64 = {32'b0, SrcA} * {32'b0, SrcB};
                    m_prod = prod64[31:0];
                    m_left = 32;
                end else begin
                    m_res = eval(code, SrcA, SrcB);
                    m_zero = (m_res == 0);
                    m_op = code;
                    m_valid = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk("valid_out", valid_out, m_valid);
            chk("result", result, m_res);
            chk("zero", zero, m_zero);
            chk("op_out", op_out, m_op);
            chk("ready_out", ready_out, m_left == 0);
            chk("busy", busy, m_left != 0);
        end
    end

    task automatic op(input logic [1:0] aop, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        valid_in = 1; ALUOp = aop; Funct = fn; SrcA = a; SrcB = b; flush = 0;
    endtask

    task automatic idle();
        @(negedge clk);
        valid_in = 0; flush = 0;
    endtask

    task automatic wait_done(input bit poke, output int lat, output int busy_cyc);
        lat = 0; busy_cyc = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk); #1;
            if (busy) busy_cyc++;
            if (valid_out) begin
                lat = k; valid_in = 0;
                return;
            end
            valid_in = poke & k[0]; ALUOp = 2'b00; Funct = 6'd0; SrcA = k; SrcB = 32'd1;
        end
        valid_in = 0;
    endtask

    localparam logic [5:0] F_MUL = 6'b011100;
    int lat, bcyc, pulses;

    initial begin
        rst_n = 0; valid_in = 0; ALUOp = 0; Funct = 0; SrcA = 0; SrcB = 0; flush = 0;
        #12;
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", zero, 1'b1);
        chk("rst_op", op_out, 3'b010);
        #10 rst_n = 1; cmp_en = 1;
        @(negedge clk); #1;
        chk("ready_after_rst", ready_out, 1'b1);

        op(2'b00, 6'd0, 32'd5, 32'd7); idle(); #1;
        chk("add_valid", valid_out, 1'b1);
        chk("add_result", result, 32'd12);
        chk("add_zero", zero, 1'b0);
        chk("add_op", op_out, 3'b010);

        op(2'b01, 6'd0, 32'h1234, 32'h1234); idle(); #1;
        chk("sub_result", result, 32'd0);
        chk("sub_zero", zero, 1'b1);

        op(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1); idle(); #1;
        chk("slt_result", result, 32'd1);
        chk("slt_op", op_out, 3'b110);

        op(2'b10, 6'b111111, 32'd3, 32'd4); idle(); #1;
        chk("undef_result", result, 32'd7);
        chk("undef_op", op_out, 3'b010);

        op(2'b10, 6'b100000, 32'd10, 32'd20);
        op(2'b10, 6'b100101, 32'hF0, 32'h0F);
        op(2'b10, 6'b100100, 32'hFF, 32'h3C);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            idle(); #1;
            if (valid_out) pulses++;
            if (i == 0) chk("b2b_and", result, 32'h3C);
        end
        chk("b2b_pulses", pulses, 1);

        op(2'b10, 6'b100010, 32'd3, 32'd5); op(2'b11, 6'd0, 32'hFFFF_FFFF, 32'd1);
        op(2'b10, 6'b101010, 32'd4, 32'hFFFF_FFFE); idle(); idle();

        op(2'b10, F_MUL, 32'd6, 32'd7);
        wait_done(1'b1, lat, bcyc);
        chk("mul_latency", lat, 33);
        chk("mul_busy_cycles", bcyc, 32);
        chk("mul_result", result, 32'd42);
        chk("mul_op", op_out, 3'b101);
        idle();

        op(2'b10, F_MUL, 32'hFFFF_FFFF, 32'd2);
        wait_done(1'b0, lat, bcyc);
        chk("mul2_result", result, 32'hFFFF_FFFE);
        op(2'b10, F_MUL, 32'h1234_5678, 32'd0);
        wait_done(1'b0, lat, bcyc);
        chk("mul0_result", result, 32'd0);
        chk("mul0_zero", zero, 1'b1);
        op(2'b10, F_MUL, 32'h8000_0001, 32'h0001_0003);
        wait_done(1'b1, lat, bcyc);
        chk("mul_wrap_lat", lat, 33);

        op(2'b00, 6'd0, 32'd100, 32'd1);
        op(2'b10, F_MUL, 32'd9, 32'd9);
        repeat (9) idle();
        @(negedge clk); valid_in = 0; flush = 1;
        idle(); #1;
        chk("flush_ready", ready_out, 1'b1);
        chk("flush_valid", valid_out, 1'b0);
        chk("flush_result", result, 32'd101);
        repeat (40) idle();

        op(2'b00, 6'd0, 32'd2, 32'd2); flush = 1;
        idle(); #1;
        chk("idle_flush_result", result, 32'd4);
        chk("idle_flush_valid", valid_out, 1'b1);

        op(2'b10, F_MUL, 32'd5, 32'd5);
        repeat (10) idle();
        #2 rst_n = 0;
        #1;
        chk("arst_valid", valid_out, 1'b0);
        chk("arst_result", result, 32'd0);
        chk("arst_zero", zero, 1'b1);
        chk("arst_busy", busy, 1'b0);
        @(negedge clk); #2 rst_n = 1;
        @(negedge clk); #1;
        chk("arst_ready", ready_out, 1'b1);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            idle(); #1;
            if (valid_out) pulses++;
        end
        chk("arst_no_completion", pulses, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
